// File: rtl/shift_pkg.sv
// Shared shift types for the left shift sequencer and the right shift register.
package shift_pkg;

  localparam int SHIFT_MODE_W = 1;

  typedef enum logic [SHIFT_MODE_W-1:0] {
    SHIFT_LOGICAL = 1'b0,
    SHIFT_ROTATE  = 1'b1
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } lshift_state_t;

endpackage

// File: rtl/left_shift_step.sv
// One-position combinational left shifter: zero fill or rotate.
// sign_change flags a two's-complement sign flip caused by this step.
module left_shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] out,
  output logic             shifted_out,
  output logic             sign_change
);

  logic fill;

  assign fill        = (mode == SHIFT_ROTATE) ? in[WIDTH-1] : 1'b0;
  assign out         = {in[WIDTH-2:0], fill};
  assign shifted_out = in[WIDTH-1];
  assign sign_change = in[WIDTH-1] ^ in[WIDTH-2];

endmodule

// File: rtl/left_shift_sequencer.sv
// Multi-cycle left shifter: one bit position per clock, logical or rotate.
// Optional sticky signed-overflow flag is built only when LSHIFT_OVERFLOW_EN
// is defined; otherwise the overflow port is tied to 0.
module left_shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amount,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow
);

  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

  lshift_state_t    state_d, state_q;
  shift_mode_t      mode_d, mode_q;
  logic [AMT_W-1:0] count_d, count_q;
  logic [WIDTH-1:0] out_d, out_q;
  logic             carry_d, carry_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;

  logic             accept;
  logic [AMT_W-1:0] amt_clamped;
  logic [WIDTH-1:0] step_out;
  logic             step_shifted_out;
  logic             step_sign_change;

  // start is honoured only between operations; mid-shift requests are dropped
  assign accept      = start && ((state_q == IDLE) || (state_q == DONE));
  assign amt_clamped = (amount > WIDTH_AMT) ? WIDTH_AMT : amount;

  left_shift_step #(.WIDTH(WIDTH)) u_step (
    .in          (out_q),
    .mode        (mode_q),
    .out         (step_out),
    .shifted_out (step_shifted_out),
    .sign_change (step_sign_change)
  );

  // Next-state, datapath and registered status outputs
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    out_d   = out_q;
    carry_d = carry_q;
    case (state_q)
      SHIFT: begin
        out_d   = step_out;
        carry_d = step_shifted_out;
        count_d = count_q - 1'b1;
        if (count_q == AMT_W'(1)) state_d = DONE;
      end
      default: begin
        // IDLE and DONE: DONE always falls back to IDLE unless restarted
        state_d = IDLE;
        if (accept) begin
          out_d   = in;
          carry_d = 1'b0;
          mode_d  = shift_mode_t'(mode);
          count_d = amt_clamped;
          state_d = (amt_clamped != '0) ? SHIFT : DONE;
        end
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= SHIFT_LOGICAL;
      count_q <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign out   = out_q;
  assign carry = carry_q;

`ifdef LSHIFT_OVERFLOW_EN
  logic overflow_d, overflow_q;

  // Sticky sign-change detect, logical shifts only; cleared on each new start
  always_comb begin
    overflow_d = overflow_q;
    if (accept)
      overflow_d = 1'b0;
    else if ((state_q == SHIFT) && (mode_q == SHIFT_LOGICAL) && step_sign_change)
      overflow_d = 1'b1;
  end

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  logic unused_sign_change;
  assign unused_sign_change = step_sign_change;
  assign overflow           = 1'b0;
`endif

endmodule
